ex_mem: RTL and testbench

Pipeline register between the execute stage and the memory stage of the five-stage MIPS core. Each cycle it captures the execute-stage result (GPR write request and HI/LO write request) and presents it to the memory stage. It honours the global stall vector and inserts bubbles where needed. It also holds the intermediate 64-bit product and cycle counter for two-cycle accumulate operations (MADD/MADDU/MSUB/MSUBU), feeding them back to the execute stage while execute is stalled.

---
 rtl/ex_mem.sv | 76 +++++++
 tb/tb_ex_mem.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/ex_mem.sv
// ex_mem: execute -> memory pipeline register for the five-stage MIPS core.
// It carries the GPR and HI/LO write requests forward one cycle. It also
// holds the intermediate product and step counter of a two-cycle accumulate,
// so execute can pick them up again on its next cycle.
module ex_mem #(
    parameter int STALL_W = 6,
    parameter int EX_IDX  = 3,
    parameter int MEM_IDX = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic               flush,
    input  logic [4:0]         ex_wd,
    input  logic               ex_wreg,
    input  logic [31:0]        ex_wdata,
    input  logic [31:0]        ex_hi,
    input  logic [31:0]        ex_lo,
    input  logic               ex_whilo,
    input  logic [63:0]        hilo_i,
    input  logic [1:0]         cnt_i,
    output logic [4:0]         mem_wd,
    output logic               mem_wreg,
    output logic [31:0]        mem_wdata,
    output logic [31:0]        mem_hi,
    output logic [31:0]        mem_lo,
    output logic               mem_whilo,
    output logic [63:0]        hilo_o,
    output logic [1:0]         cnt_o
);

    // Execute is held while memory keeps moving: a NOP goes down the pipe.
    logic bubble;
    // Memory is held; this includes the illegal pattern with execute running.
    logic hold;

    assign bubble = stall[EX_IDX] && !stall[MEM_IDX];
    assign hold   = stall[MEM_IDX];

    // Priority: reset, flush, bubble, hold, advance. Hold assigns nothing.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            mem_wd    <= 5'd0;
            mem_wreg  <= 1'b0;
            mem_wdata <= 32'h0;
            mem_hi    <= 32'h0;
            mem_lo    <= 32'h0;
            mem_whilo <= 1'b0;
            hilo_o    <= 64'h0;
            cnt_o     <= 2'b00;
        end else if (bubble) begin
            // The NOP writes nothing, but the accumulate state is kept
            // so the stalled multi-cycle op can finish next cycle.
            mem_wd    <= 5'd0;
            mem_wreg  <= 1'b0;
            mem_wdata <= 32'h0;
            mem_hi    <= 32'h0;
            mem_lo    <= 32'h0;
            mem_whilo <= 1'b0;
            hilo_o    <= hilo_i;
            cnt_o     <= cnt_i;
        end else if (!hold) begin
            // Normal advance; temp state is cleared so a finished
            // accumulate leaves nothing stale behind.
            mem_wd    <= ex_wd;
            mem_wreg  <= ex_wreg;
            mem_wdata <= ex_wdata;
            mem_hi    <= ex_hi;
            mem_lo    <= ex_lo;
            mem_whilo <= ex_whilo;
            hilo_o    <= 64'h0;
            cnt_o     <= 2'b00;
        end
    end

endmodule

// File: tb/tb_ex_mem.sv
// Directed testbench for ex_mem with hand-computed expected values.
module tb_ex_mem;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic [4:0]  ex_wd;
    logic        ex_wreg;
    logic [31:0] ex_wdata;
    logic [31:0] ex_hi;
    logic [31:0] ex_lo;
    logic        ex_whilo;
    logic [63:0] hilo_i;
    logic [1:0]  cnt_i;
    logic [4:0]  mem_wd;
    logic        mem_wreg;
    logic [31:0] mem_wdata;
    logic [31:0] mem_hi;
    logic [31:0] mem_lo;
    logic        mem_whilo;
    logic [63:0] hilo_o;
    logic [1:0]  cnt_o;

    int total = 0;
    int bad   = 0;

    ex_mem #(.STALL_W(6), .EX_IDX(3), .MEM_IDX(4)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata),
        .ex_hi(ex_hi), .ex_lo(ex_lo), .ex_whilo(ex_whilo),
        .hilo_i(hilo_i), .cnt_i(cnt_i),
        .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
        .mem_hi(mem_hi), .mem_lo(mem_lo), .mem_whilo(mem_whilo),
        .hilo_o(hilo_o), .cnt_o(cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one edge and land 1 time unit after it, away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_pipe(input string tag, input logic [4:0] wd, input logic wreg,
                            input logic [31:0] wdata, input logic [31:0] hi,
                            input logic [31:0] lo, input logic whilo);
        chk({tag, ".wd"},    64'(mem_wd),    64'(wd));
        chk({tag, ".wreg"},  64'(mem_wreg),  64'(wreg));
        chk({tag, ".wdata"}, 64'(mem_wdata), 64'(wdata));
        chk({tag, ".hi"},    64'(mem_hi),    64'(hi));
        chk({tag, ".lo"},    64'(mem_lo),    64'(lo));
        chk({tag, ".whilo"}, 64'(mem_whilo), 64'(whilo));
    endtask

    task automatic chk_tmp(input string tag, input logic [63:0] hilo, input logic [1:0] cnt);
        chk({tag, ".hilo"}, hilo_o, hilo);
        chk({tag, ".cnt"},  64'(cnt_o), 64'(cnt));
    endtask

    initial begin
        // Reset with every input nonzero.
        rst = 1'b1; stall = 6'b000000; flush = 1'b0;
        ex_wd = 5'd31; ex_wreg = 1'b1; ex_wdata = 32'hA5A5A5A5;
        ex_hi = 32'h11111111; ex_lo = 32'h22222222; ex_whilo = 1'b1;
        hilo_i = 64'hFFFF_0000_FFFF_0000; cnt_i = 2'b11;
        #2;
        tick();
        chk_pipe("reset", 5'd0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
        chk_tmp("reset", 64'h0, 2'b00);

        // Pass-through, then back-to-back second value.
        rst = 1'b0;
        ex_wd = 5'd8; ex_wreg = 1'b1; ex_wdata = 32'hDEADBEEF;
        ex_hi = 32'h0; ex_lo = 32'h0; ex_whilo = 1'b0;
        tick();
        chk_pipe("pass1", 5'd8, 1'b1, 32'hDEADBEEF, 32'h0, 32'h0, 1'b0);
        chk_tmp("pass1", 64'h0, 2'b00);
        ex_wd = 5'd9; ex_wdata = 32'hCAFEF00D;
        #3;
        chk_pipe("pass2_pre", 5'd8, 1'b1, 32'hDEADBEEF, 32'h0, 32'h0, 1'b0);
        tick();
        chk_pipe("pass2", 5'd9, 1'b1, 32'hCAFEF00D, 32'h0, 32'h0, 1'b0);

        // Bubble with temp capture.
        stall = 6'b001111; hilo_i = 64'h0000_0001_0000_0002; cnt_i = 2'b01;
        ex_wreg = 1'b1; ex_whilo = 1'b1; ex_hi = 32'h3; ex_lo = 32'h4;
        tick();
        chk_pipe("bubble", 5'd0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
        chk_tmp("bubble", 64'h0000_0001_0000_0002, 2'b01);
        stall = 6'b000000; ex_wd = 5'd2; ex_wdata = 32'h55; ex_whilo = 1'b0;
        tick();
        chk_pipe("bubble_rel", 5'd2, 1'b1, 32'h55, 32'h3, 32'h4, 1'b0);
        chk_tmp("bubble_rel", 64'h0, 2'b00);

        // Memory hold for 3 cycles with changing inputs.
        ex_wd = 5'd3; ex_wreg = 1'b1; ex_wdata = 32'h12345678;
        ex_hi = 32'hAA; ex_lo = 32'hBB; ex_whilo = 1'b1;
        tick();
        chk_pipe("load", 5'd3, 1'b1, 32'h12345678, 32'hAA, 32'hBB, 1'b1);
        stall = 6'b011111;
        for (int i = 0; i < 3; i++) begin
            ex_wd = 5'(10 + i); ex_wreg = i[0]; ex_wdata = 32'h1000 + 32'(i);
            ex_hi = 32'(i); ex_lo = ~32'(i); ex_whilo = 1'b0;
            hilo_i = 64'h77 + 64'(i); cnt_i = 2'b10;
            tick();
            chk_pipe("hold", 5'd3, 1'b1, 32'h12345678, 32'hAA, 32'hBB, 1'b1);
            chk_tmp("hold", 64'h0, 2'b00);
        end
        stall = 6'b000000;
        tick();
        chk_pipe("hold_rel", 5'd12, 1'b0, 32'h1002, 32'h2, 32'hFFFFFFFD, 1'b0);

        // Hold also keeps accumulate state captured by a bubble.
        stall = 6'b001111; hilo_i = 64'h0123_4567_89AB_CDEF; cnt_i = 2'b10;
        tick();
        chk_tmp("acc_cap", 64'h0123_4567_89AB_CDEF, 2'b10);
        stall = 6'b011111; hilo_i = 64'h0; cnt_i = 2'b00;
        tick();
        chk_tmp("acc_hold", 64'h0123_4567_89AB_CDEF, 2'b10);

        // Flush over a bubble stall pattern.
        stall = 6'b001111; flush = 1'b1; cnt_i = 2'b01; hilo_i = 64'h99;
        tick();
        chk_pipe("flush", 5'd0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
        chk_tmp("flush", 64'h0, 2'b00);

        // Flush over a memory hold.
        flush = 1'b0; stall = 6'b000000;
        ex_wd = 5'd7; ex_wreg = 1'b1; ex_wdata = 32'h77;
        tick();
        stall = 6'b011111; flush = 1'b1;
        tick();
        chk_pipe("flush_hold", 5'd0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);

        // HI/LO path.
        flush = 1'b0; stall = 6'b000000;
        ex_whilo = 1'b1; ex_hi = 32'hFFFF_FFFF; ex_lo = 32'h1; ex_wreg = 1'b0;
        ex_wd = 5'd0; ex_wdata = 32'h0;
        tick();
        chk_pipe("hilo", 5'd0, 1'b0, 32'h0, 32'hFFFF_FFFF, 32'h1, 1'b1);

        // Illegal pattern (memory stalled, execute running) holds.
        stall = 6'b010000; ex_hi = 32'h5; ex_whilo = 1'b0;
        tick();
        chk_pipe("illegal", 5'd0, 1'b0, 32'h0, 32'hFFFF_FFFF, 32'h1, 1'b1);

        // Reset mid-accumulate discards temp state.
        stall = 6'b001111; hilo_i = 64'hDEAD; cnt_i = 2'b01;
        tick();
        chk_tmp("mid_acc", 64'hDEAD, 2'b01);
        rst = 1'b1;
        tick();
        chk_pipe("rst_acc", 5'd0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
        chk_tmp("rst_acc", 64'h0, 2'b00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
